apb_slave_mem_param: RTL
========================

Name: apb_slave_mem_param

Overview:
- Parametrised APB4 slave memory and successor to the fixed 32x32 APB slave memory.
- Configurable data width, depth and wait states; APB4 byte strobes (pstrb).
- Decodes out-of-range and misaligned errors, and keeps a saturating error counter.
- Sits behind the APB interconnect as a scratch/config RAM, one pselx per instance.

Parameters:
DATA_W, 32, data bus width; legal values 32 or 64
ADDR_W, 32, paddr width
DEPTH, 32, number of DATA_W words; any value >= 2, not necessarily a power of two
WAIT_STATES, 0, number of ACCESS cycles with pready=0 before completion; range 0..15
ERRCNT_W, 8, width of the error counter

Ports:
pclk  input  1  APB clock
prst_n  input  1  asynchronous active-low reset
pselx  input  1  slave select
penable  input  1  APB access-phase strobe
pwrite  input  1  1=write, 0=read
paddr  input  ADDR_W  byte address
pwdata  input  DATA_W  write data
pstrb  input  DATA_W/8  write byte strobes; ignored on reads
pready  output  1  transfer completion
pslverr  output  1  error response; valid only while pready=1
prdata  output  DATA_W  read data; valid only while pready=1
err_cnt  output  ERRCNT_W  saturating count of completed transfers with pslverr=1

Behaviour:
- Reset: prst_n is asynchronous and active-low; pclk is the clock.
- Reset values: state=IDLE, wait counter=0, err_cnt=0, pready=0, pslverr=0, prdata=0. Memory contents are not reset.
- Definitions:
  - LSB = log2(DATA_W/8).
  - idx = paddr[ADDR_W-1:LSB].
  - err = (idx >= DEPTH) | (paddr[LSB-1:0] != 0).
- FSM states: IDLE, ACCESS.
  - IDLE -> ACCESS when pselx & !penable (setup phase); wcnt loads WAIT_STATES.
  - ACCESS, pselx & penable, wcnt != 0: wcnt decrements; stay in ACCESS.
  - ACCESS, pselx & penable, wcnt == 0: completion cycle; next state is IDLE.
  - ACCESS, pselx=0: protocol abort; go to IDLE with no write and no err_cnt change.
  - ACCESS, pselx=1 & penable=0: treated as a new setup; reload wcnt and stay in ACCESS.
- Outputs are combinational from registered state:
  - pready = (state==ACCESS) & (wcnt==0) & pselx & penable.
  - pslverr = pready & err.
  - prdata = mem[idx] when pready & !pwrite & !err, else 0.
- Latency: a transfer occupies setup + (WAIT_STATES+1) access cycles. With WAIT_STATES=0 that is 2 cycles, matching APB zero-wait.
- Back-to-back transfers: a setup in the cycle right after completion is accepted (IDLE sees pselx & !penable). No idle cycle is required.
- Write commit:
  - Happens at the pclk edge ending the completion cycle, only when pwrite & !err.
  - Each byte lane b is updated only where pstrb[b]=1.
  - pstrb=0 is a legal no-op write with no error.
- Errored writes never modify memory. Errored reads return prdata=0.
- err_cnt increments by 1 at every completion cycle with pslverr=1 and saturates at 2^ERRCNT_W-1 without wrapping.
- Address, write data and strobes are sampled in the completion cycle. Per APB rules the master holds them stable from setup.
- Reset asserted mid-transfer forces IDLE immediately. The pending write is dropped, err_cnt is cleared, and memory keeps its prior contents.
- Synthesizable as a flop array. No read-during-write hazard exists, because only one transfer is in flight at a time.

Decomposition:
- Shared package apb_pkg:
  - state enum (IDLE, ACCESS);
  - function strb_merge(old, new, strb) for byte-lane merging;
  - constant localparam helpers for the LSB calculation.
- One sub-module, apb_mem_array:
  - parameters DATA_W, DEPTH;
  - byte-enabled write port (we, widx, wdata, wstrb);
  - combinational read port (ridx, rdata).
- The top level holds the FSM, wait counter, error decode and err_cnt.

Test Plan:
1. Reset check: hold prst_n=0, then release -> pready=0, pslverr=0, prdata=0, err_cnt=0. Re-assert reset mid-wait with WAIT_STATES=3 -> pready stays 0 and the pending write is not committed.
2. Basic write/read, WAIT_STATES=0: write 0xDEADBEEF to 0x10 with pstrb=4'hF -> pready=1 in the first access cycle. Read 0x10 -> prdata=0xDEADBEEF, pslverr=0.
3. Byte strobes: write 0x11223344 to 0x10 with pstrb=4'b0101 -> read returns 0xDE22BE44. Write with pstrb=0 -> data unchanged, pslverr=0.
4. Errors, DEPTH=32:
   - write to 0x80 -> pslverr=1, mem[0] unchanged, err_cnt=1;
   - read 0x02 -> pslverr=1, prdata=0, err_cnt=2;
   - with ERRCNT_W=2, 5 errors -> err_cnt=3.
5. Wait states, WAIT_STATES=2: pready=0 for 2 access cycles and 1 on the 3rd. Three back-to-back writes with no idle cycles all commit, and read-back matches.
6. Abort: deassert pselx in the second access cycle of a write (WAIT_STATES=2) -> FSM returns to IDLE, memory unchanged, err_cnt unchanged.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and helpers for the parametrised APB slave memory.
// Holds the FSM state enum, byte-lane merge and address LSB helper.
package apb_pkg;

  typedef enum logic {
    IDLE,
    ACCESS
  } apb_state_e;

  localparam int MAX_W = 64;

  // Byte offset bits of a word address for a given bus width.
  function automatic int lsb_of(input int dw);
    return $clog2(dw / 8);
  endfunction

  // Replace the byte lanes selected by strb with the new data.
  function automatic logic [MAX_W-1:0] strb_merge(
    input logic [MAX_W-1:0] old_d,
    input logic [MAX_W-1:0] new_d,
    input logic [7:0]       strb
  );
    logic [MAX_W-1:0] r;
    for (int b = 0; b < 8; b++) begin
      r[b*8 +: 8] = strb[b] ? new_d[b*8 +: 8] : old_d[b*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/apb_mem_array.sv
// Byte-enabled flop-array memory with one write and one read port.
// Contents are deliberately not reset.
module apb_mem_array
  import apb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] widx,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [DATA_W/8-1:0]      wstrb,
  input  logic [$clog2(DEPTH)-1:0] ridx,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] word_d;

  // Merge the strobed lanes into the addressed word.
  always_comb begin
    word_d = DATA_W'(strb_merge(MAX_W'(mem_q[widx]),
                                MAX_W'(wdata),
                                8'(wstrb)));
  end

  // Commit the merged word on a qualified write.
  always_ff @(posedge clk) begin
    if (we) mem_q[widx] <= word_d;
  end

  assign rdata = mem_q[ridx];

endmodule

// File: rtl/apb_slave_mem_param.sv
// APB4 slave scratch RAM with wait states, strobes and error decode.
// FSM, wait counter and saturating error counter live here.
module apb_slave_mem_param
  import apb_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 32,
  parameter int WAIT_STATES = 0,
  parameter int ERRCNT_W    = 8
) (
  input  logic                pclk,
  input  logic                prst_n,
  input  logic                pselx,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [ADDR_W-1:0]   paddr,
  input  logic [DATA_W-1:0]   pwdata,
  input  logic [DATA_W/8-1:0] pstrb,
  output logic                pready,
  output logic                pslverr,
  output logic [DATA_W-1:0]   prdata,
  output logic [ERRCNT_W-1:0] err_cnt
);

  localparam int LSB   = lsb_of(DATA_W);
  localparam int IDX_W = ADDR_W - LSB;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [3:0] WS = 4'(WAIT_STATES);
  localparam logic [IDX_W:0] DEPTH_X = (IDX_W+1)'(DEPTH);

  apb_state_e          state_q, state_d;
  logic [3:0]          wcnt_q, wcnt_d;
  logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [IDX_W-1:0]  idx;
  logic              err;
  logic              we;
  logic [DATA_W-1:0] rdata;

  assign idx = paddr[ADDR_W-1:LSB];
  assign err = ({1'b0, idx} >= DEPTH_X) |
               (paddr[LSB-1:0] != '0);

  assign pready  = (state_q == ACCESS) & (wcnt_q == 4'd0) &
                   pselx & penable;
  assign pslverr = pready & err;
  assign prdata  = (pready & ~pwrite & ~err) ? rdata : '0;
  assign err_cnt = err_cnt_q;
  assign we      = pready & pwrite & ~err;

  // Next state, wait countdown and error counter update.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    err_cnt_d = err_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pselx && !penable) begin
          state_d = ACCESS;
          wcnt_d  = WS;
        end
      end
      ACCESS: begin
        if (!pselx) begin
          state_d = IDLE;
        end else if (!penable) begin
          wcnt_d = WS;
        end else if (wcnt_q != 4'd0) begin
          wcnt_d = wcnt_q - 4'd1;
        end else begin
          state_d = IDLE;
          if (err && err_cnt_q != '1)
            err_cnt_d = err_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      state_q   <= IDLE;
      wcnt_q    <= 4'd0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  apb_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (pclk),
    .we    (we),
    .widx  (idx[AW-1:0]),
    .wdata (pwdata),
    .wstrb (pstrb),
    .ridx  (idx[AW-1:0]),
    .rdata (rdata)
  );

endmodule
